// File: rtl/log_pkg.sv
// Shared definitions for the log2 input normalizer and the downstream Log10/log2 stage.
package log_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int LOG_WI = 8;
  localparam int LOG_WF = 32;
  localparam int LOG_WM = 32;

  // Smallest two's-complement width that holds every exponent in -wf..wi-2.
  function automatic int log_min_ew(input int wi, input int wf);
    int res;
    res = 32;
    for (int b = 31; b >= 1; b--) begin
      if ((-(1 << (b - 1)) <= -wf) && (((1 << (b - 1)) - 1) >= (wi - 2))) res = b;
    end
    return res;
  endfunction

endpackage

// File: rtl/log2_normalizer.sv
// Sequential normalizer: shifts a positive WI.WF operand left one bit per cycle
// until its leading one reaches the top magnitude bit, yielding Mant in [1,2) and Exp.
module log2_normalizer
  import log_pkg::*;
#(
  parameter int WI = LOG_WI,
  parameter int WF = LOG_WF,
  parameter int WM = LOG_WM,
  parameter int EW = 7
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [WI+WF-1:0] NumIn,
  input  logic          InValid,
  output logic          InReady,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [WM:0]   Mant,
  output logic [EW-1:0] Exp,
  output logic          Zero,
  output logic          Negflow,
  output state_e        dbg_state
);

  localparam int N  = WI + WF;
  localparam int RW = N - 1;
  localparam logic [EW-1:0] EXP_INIT = EW'(WI - 2);
  localparam logic [EW-1:0] EXP_ONE  = EW'(1);

  if (EW < log_min_ew(WI, WF)) begin : g_ew_check
    $error("EW too narrow for exponent range -WF..WI-2");
  end

  // Handshake: input accepted on an edge where InValid && InReady; result
  // consumed on an edge where OutValid && OutReady. No same-cycle bypass.
  state_e          state_q, state_d;
  logic [RW-1:0]   work_q, work_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic            zero_q, zero_d;
  logic            neg_q, neg_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    exp_d       = exp_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (InValid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (NumIn[N-1] || (NumIn == '0)) begin
            // Non-positive operand: flag it and skip normalization entirely.
            work_d      = '0;
            exp_d       = '0;
            neg_d       = 1'b1;
            zero_d      = ~NumIn[N-1];
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            work_d  = NumIn[N-2:0];
            exp_d   = EXP_INIT;
            neg_d   = 1'b0;
            zero_d  = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (work_q[RW-1]) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          work_d = {work_q[RW-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end
      end
      DONE: begin
        if (OutReady) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      exp_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      exp_q       <= exp_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Mantissa is the top WM+1 bits of the working register; excess low bits truncate.
  if (WM <= RW - 1) begin : g_mant_trunc
    assign Mant = work_q[RW-1 -: WM+1];
    if (WM < RW - 1) begin : g_low
      logic unused_low_bits;
      assign unused_low_bits = ^work_q[RW-2-WM:0];
    end
  end else begin : g_mant_pad
    assign Mant = {work_q, {(WM + 1 - RW){1'b0}}};
  end

  assign InReady   = in_ready_q;
  assign OutValid  = out_valid_q;
  assign Exp       = exp_q;
  assign Zero      = zero_q;
  assign Negflow   = neg_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_log2_normalizer.sv
// Randomized and directed bench for log2_normalizer against a behavioural model.
module tb_log2_normalizer;
  import log_pkg::*;

  localparam int WI   = 8;
  localparam int WF   = 32;
  localparam int WM   = 32;
  localparam int EW   = 7;
  localparam int N    = WI + WF;
  localparam int EXPW = WM + 1 + EW + 2;

  logic          Clk;
  logic          Rst;
  logic [N-1:0]  NumIn;
  logic          InValid;
  logic          InReady;
  logic          OutValid;
  logic          OutReady;
  logic [WM:0]   Mant;
  logic [EW-1:0] Exp;
  logic          Zero;
  logic          Negflow;
  state_e        dbg_state;

  log2_normalizer #(.WI(WI), .WF(WF), .WM(WM), .EW(EW)) dut (
    .Clk(Clk), .Rst(Rst), .NumIn(NumIn), .InValid(InValid), .InReady(InReady),
    .OutValid(OutValid), .OutReady(OutReady), .Mant(Mant), .Exp(Exp),
    .Zero(Zero), .Negflow(Negflow), .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  logic [EXPW-1:0] exp_q[$];
  bit model_busy = 0;

  // clock / reset
  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: locate the leading one, exponent is its weight, mantissa is the
  // value scaled so that leading one sits at Mant[WM].
  function automatic logic [EXPW-1:0] model(input logic [N-1:0] v, output int lat);
    logic [WM:0]   m;
    logic [63:0]   wide;
    int            e;
    int            p;
    logic          z;
    logic          ng;
    m = '0; e = 0; z = 0; ng = 0; lat = 0;
    if (v[N-1]) begin
      ng = 1;
    end else if (v == '0) begin
      ng = 1;
      z  = 1;
    end else begin
      p = 0;
      for (int i = 0; i < N - 1; i++) if (v[i]) p = i;
      e    = p - WF;
      lat  = (N - 2 - p) + 1;
      wide = {24'b0, v} << (N - 2 - p);
      wide = wide >> (N - 2 - WM);
      m    = wide[WM:0];
    end
    return {m, EW'(e), z, ng};
  endfunction

  function automatic logic [N-1:0] rand_operand();
    logic [63:0]  r;
    logic [N-1:0] v;
    logic [N-1:0] one;
    int           p;
    int           kind;
    r    = {$urandom, $urandom};
    v    = r[N-1:0];
    one  = 1;
    kind = $urandom_range(0, 9);
    if (kind == 0) return '0;
    if (kind == 1) begin
      v[N-1] = 1'b1;
      return v;
    end
    p = $urandom_range(0, N - 2);
    v = (v & ((one << p) - one)) | (one << p);
    return v;
  endfunction

  // scoreboard compare: runs every cycle while out of reset
  always @(negedge Clk) begin
    if (Rst) begin
      check("in_ready_vs_model", InReady, !model_busy);
      if (!model_busy) check("out_valid_idle", OutValid, 0);
      if (OutValid) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result", {Mant, Exp, Zero, Negflow}, exp_q[0]);
      end
    end
  end

  // driver: send one operand, wait for the result, optionally backpressure
  task automatic run_op(input logic [N-1:0] v, input int hold, input bit early_ready, input bit poke);
    int lat;
    int exp_lat;
    int waited;
    logic [EXPW-1:0] e;
    logic [63:0] r;
    waited = 0;
    while (!InReady && waited < 100) begin
      @(posedge Clk); #1;
      waited++;
    end
    check("in_ready_before_send", InReady, 1);
    e        = model(v, exp_lat);
    NumIn    = v;
    InValid  = 1;
    OutReady = early_ready;
    @(posedge Clk);
    exp_q.push_back(e);
    model_busy = 1;
    #1;
    InValid = 0;
    r       = {$urandom, $urandom};
    NumIn   = r[N-1:0];
    lat     = 0;
    while (!OutValid && lat < N + 5) begin
      @(posedge Clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    if (!early_ready) begin
      for (int i = 0; i < hold; i++) begin
        if (poke) begin
          r       = {$urandom, $urandom};
          InValid = 1;
          NumIn   = r[N-1:0];
        end
        @(posedge Clk); #1;
        check("hold_in_ready_low", InReady, 0);
      end
      InValid  = 0;
      OutReady = 1;
    end
    @(posedge Clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_busy = 0;
    #1;
    OutReady = 0;
    check("out_valid_drop", OutValid, 0);
    check("in_ready_after", InReady, 1);
  endtask

  initial begin
    int l;
    logic [EXPW-1:0] m;
    Rst = 0; NumIn = '0; InValid = 0; OutReady = 0;

    // model pins
    m = model(40'h02_00000000, l);
    check("pin_two_res", m, {33'h1_0000_0000, 7'd1, 1'b0, 1'b0});
    check("pin_two_lat", l, 6);
    m = model(40'h5A_01EB851E, l);
    check("pin_90_res", m, {33'h1_6807_AE14, 7'd6, 1'b0, 1'b0});
    check("pin_90_lat", l, 1);
    m = model(40'h00_00000001, l);
    check("pin_min_res", m, {33'h1_0000_0000, 7'h60, 1'b0, 1'b0});
    check("pin_min_lat", l, 39);
    m = model(40'h80_00000000, l);
    check("pin_neg_res", m, {33'h0, 7'd0, 1'b0, 1'b1});

    // reset values
    #12;
    check("rst_in_ready", InReady, 1);
    check("rst_out_valid", OutValid, 0);
    check("rst_outputs", {Mant, Exp, Zero, Negflow}, '0);
    @(negedge Clk); Rst = 1;
    @(posedge Clk); #1;

    // directed
    run_op(40'h02_00000000, 0, 0, 0);
    run_op(40'h5A_01EB851E, 1, 0, 0);
    run_op(40'h00_00000001, 0, 0, 0);
    run_op(40'h00_00000000, 0, 0, 0);
    run_op(40'h80_00000000, 2, 0, 0);
    run_op(40'h7F_FFFFFFFF, 0, 1, 0);
    run_op(40'h02_00000000, 5, 0, 1);

    // reset mid-operation on a k=38 operand
    NumIn = 40'h00_00000001; InValid = 1;
    @(posedge Clk);
    model_busy = 1;
    #1 InValid = 0;
    repeat (9) @(posedge Clk);
    #3 Rst = 0;
    #1;
    exp_q.delete();
    model_busy = 0;
    check("mid_rst_out_valid", OutValid, 0);
    check("mid_rst_in_ready", InReady, 1);
    check("mid_rst_outputs", {Mant, Exp, Zero, Negflow}, '0);
    @(posedge Clk); #1;
    check("held_rst_out_valid", OutValid, 0);
    @(negedge Clk); Rst = 1;
    @(posedge Clk); #1;
    run_op(40'h02_00000000, 0, 0, 0);

    // random
    for (int i = 0; i < 40; i++) begin
      run_op(rand_operand(), $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end

    repeat (3) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
